inport_conditioner: RTL and testbench

//   Upstream stage of datapath_phase3. Conditions raw board inputs (DATA_W slide switches + one
//   "enter" pushbutton) into the 32-bit inport_ext_input word the datapath's IN port samples.
//   A debounced button press captures the switches and raises a ready flag. The flag clears

---
 rtl/inport_conditioner_pkg.sv | 16 +
 rtl/inport_conditioner_debounce.sv | 68 ++++++
 rtl/inport_conditioner.sv | 95 +++++++++
 tb/tb_inport_conditioner.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/inport_conditioner_pkg.sv
// Shared definitions for the in-port conditioner: debounce states and status bit positions.
package inport_conditioner_pkg;

  // Debounce FSM states; encodings are fixed so they read the same on a logic analyser.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_e;

  // Positions of the status flags in the 32-bit in-port word.
  localparam int READY_BIT   = 31;
  localparam int OVERRUN_BIT = 30;

endpackage

// File: rtl/inport_conditioner_debounce.sv
// Debounce state machine: turns a synchronized button level into one accept pulse per press.
module debounce_fsm
  import inport_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic fast_clk,
  input  logic reset,
  input  logic in_s,
  output logic accept_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  debounce_state_e state_q;
  logic [CNT_W-1:0] cnt_q;

  // The accept pulse marks the exact edge on which PRESS_WAIT completes, so the
  // capture register in the parent can load on that same edge without an extra cycle.
  assign accept_pulse = (state_q == PRESS_WAIT) && in_s && (cnt_q == CNT_LAST);

  // Press/release debouncing; the counter stops at its terminal value because the state moves on there.
  always_ff @(posedge fast_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!in_s) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!in_s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (in_s) begin
            state_q <= PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/inport_conditioner.sv
// Conditions raw switches and the enter button into the datapath's 32-bit IN-port word.
module inport_conditioner
  import inport_conditioner_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              fast_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_in,
  input  logic              btn_in,
  input  logic              inport_rd,
  output logic [31:0]       inport_ext_input,
  output logic              data_ready,
  output logic              overrun
);

  logic              btnSync1_q, btnSync_q;
  logic [DATA_W-1:0] swSync1_q, swSync_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              overrun_q, overrun_d;
  logic              acceptPulse;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge fast_clk) begin
    if (reset) begin
      btnSync1_q <= 1'b0;
      btnSync_q  <= 1'b0;
      swSync1_q  <= '0;
      swSync_q   <= '0;
    end else begin
      btnSync1_q <= btn_in;
      btnSync_q  <= btnSync1_q;
      swSync1_q  <= sw_in;
      swSync_q   <= swSync1_q;
    end
  end

  debounce_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .fast_clk    (fast_clk),
    .reset       (reset),
    .in_s        (btnSync_q),
    .accept_pulse(acceptPulse)
  );

  // Capture and ready/overrun bookkeeping; a capture on the same edge as a read
  // counts the old value as consumed, so overrun clears instead of setting.
  always_comb begin
    data_d    = data_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    if (acceptPulse) begin
      data_d  = swSync_q;
      ready_d = 1'b1;
      if (ready_q && inport_rd) begin
        overrun_d = 1'b0;
      end else if (ready_q) begin
        overrun_d = 1'b1;
      end
    end else if (inport_rd && ready_q) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Capture register and status flags.
  always_ff @(posedge fast_clk) begin
    if (reset) begin
      data_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  // Output word is pure wiring of registers, so nothing combinational reaches the port.
  always_comb begin
    inport_ext_input                   = '0;
    inport_ext_input[DATA_W-1:0]       = data_q;
    inport_ext_input[READY_BIT]        = ready_q;
    inport_ext_input[OVERRUN_BIT]      = overrun_q;
  end

  assign data_ready = ready_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_inport_conditioner.sv
// Directed bench for inport_conditioner with a short debounce window.
module tb_inport_conditioner;
  import inport_conditioner_pkg::*;

  localparam int DATA_W          = 8;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CNT_W           = 16;

  logic              fast_clk;
  logic              reset;
  logic [DATA_W-1:0] sw_in;
  logic              btn_in;
  logic              inport_rd;
  logic [31:0]       inport_ext_input;
  logic              data_ready;
  logic              overrun;

  int errorCount;
  int checkCount;

  inport_conditioner #(
    .DATA_W         (DATA_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .fast_clk        (fast_clk),
    .reset           (reset),
    .sw_in           (sw_in),
    .btn_in          (btn_in),
    .inport_rd       (inport_rd),
    .inport_ext_input(inport_ext_input),
    .data_ready      (data_ready),
    .overrun         (overrun)
  );

  // 10 ns clock; rising edges at 5, 15, 25 ns...
  initial begin
    fast_clk = 1'b0;
    forever #5 fast_clk = ~fast_clk;
  end

  // Compare one observed value against its expected value and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive inputs just after a falling edge and hold them for the given number of cycles.
  task automatic applyStimulus(input logic [DATA_W-1:0] sw, input logic btn, input logic rd, input int cycles);
    sw_in     = sw;
    btn_in    = btn;
    inport_rd = rd;
    repeat (cycles) @(negedge fast_clk);
  endtask

  // Directed sequence; every check samples on a falling edge.
  initial begin
    errorCount = 0;
    checkCount = 0;
    reset      = 1'b1;
    sw_in      = 8'hFF;
    btn_in     = 1'b1;
    inport_rd  = 1'b0;

    repeat (2) @(negedge fast_clk);
    checkOutput("reset_word", inport_ext_input, 32'h0);
    checkOutput("reset_state", {30'b0, dut.u_debounce.state_q}, {30'b0, IDLE});

    reset = 1'b0;
    applyStimulus(8'hA5, 1'b0, 1'b0, 8);
    checkOutput("idle_word", inport_ext_input, 32'h0);

    applyStimulus(8'hA5, 1'b1, 1'b0, 6);
    checkOutput("press_early", inport_ext_input, 32'h0);
    applyStimulus(8'hA5, 1'b1, 1'b0, 1);
    checkOutput("press_A5", inport_ext_input, 32'h800000A5);
    checkOutput("press_A5_ready", {31'b0, data_ready}, 32'd1);
    checkOutput("press_A5_ovr", {31'b0, overrun}, 32'd0);

    applyStimulus(8'hA5, 1'b1, 1'b1, 1);
    checkOutput("read_A5", inport_ext_input, 32'h000000A5);
    applyStimulus(8'hA5, 1'b1, 1'b1, 1);
    checkOutput("read_not_ready", inport_ext_input, 32'h000000A5);

    applyStimulus(8'hA5, 1'b0, 1'b0, 8);
    applyStimulus(8'h3C, 1'b1, 1'b0, 7);
    checkOutput("press_3C", inport_ext_input, 32'h8000003C);
    applyStimulus(8'h3C, 1'b0, 1'b0, 8);
    applyStimulus(8'h11, 1'b1, 1'b0, 7);
    checkOutput("overrun_11", inport_ext_input, 32'hC0000011);
    checkOutput("overrun_port", {31'b0, overrun}, 32'd1);

    applyStimulus(8'h22, 1'b0, 1'b0, 3);
    applyStimulus(8'h22, 1'b1, 1'b0, 10);
    checkOutput("release_bounce_word", inport_ext_input, 32'hC0000011);
    checkOutput("release_bounce_state", {30'b0, dut.u_debounce.state_q}, {30'b0, PRESSED});

    applyStimulus(8'h22, 1'b1, 1'b1, 1);
    checkOutput("read_11", inport_ext_input, 32'h00000011);
    applyStimulus(8'h22, 1'b0, 1'b0, 8);

    applyStimulus(8'h77, 1'b1, 1'b0, 2);
    applyStimulus(8'h77, 1'b0, 1'b0, 10);
    checkOutput("glitch2_word", inport_ext_input, 32'h00000011);
    checkOutput("glitch2_state", {30'b0, dut.u_debounce.state_q}, {30'b0, IDLE});
    applyStimulus(8'h77, 1'b1, 1'b0, 4);
    applyStimulus(8'h77, 1'b0, 1'b0, 10);
    checkOutput("glitch4_word", inport_ext_input, 32'h00000011);
    applyStimulus(8'h77, 1'b1, 1'b0, 5);
    applyStimulus(8'h77, 1'b0, 1'b0, 10);
    checkOutput("pulse5_word", inport_ext_input, 32'h80000077);

    applyStimulus(8'h5A, 1'b1, 1'b0, 6);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1);
    checkOutput("capture_with_read", inport_ext_input, 32'h8000005A);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1);
    checkOutput("read_5A", inport_ext_input, 32'h0000005A);
    applyStimulus(8'h5A, 1'b0, 1'b0, 8);

    applyStimulus(8'hC3, 1'b1, 1'b0, 5);
    checkOutput("mid_state", {30'b0, dut.u_debounce.state_q}, {30'b0, PRESS_WAIT});
    checkOutput("mid_cnt", {16'b0, dut.u_debounce.cnt_q}, 32'd2);
    reset = 1'b1;
    applyStimulus(8'hC3, 1'b1, 1'b0, 1);
    checkOutput("mid_reset_word", inport_ext_input, 32'h0);
    checkOutput("mid_reset_state", {30'b0, dut.u_debounce.state_q}, {30'b0, IDLE});
    reset = 1'b0;
    applyStimulus(8'hC3, 1'b1, 1'b0, 6);
    checkOutput("after_reset_early", inport_ext_input, 32'h0);
    applyStimulus(8'hC3, 1'b1, 1'b0, 1);
    checkOutput("after_reset_C3", inport_ext_input, 32'h800000C3);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
